fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000: instruction word inserted as a bubble.
REQ-003 Clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Rst  input  1: asynchronous, active-low reset.
REQ-005 Instruction  input  32: word returned by instruction memory for Address, same cycle (combinational memory).
REQ-006 Address  output  32: current PC, driven to instruction memory.
REQ-007 Stall  input  1: hazard hold request from decode.
REQ-008 Flush  input  1: squash the IF/ID contents.
REQ-009 BranchTaken  input  1: branch redirect request.
REQ-010 BranchTarget  input  32: branch redirect address.
REQ-011 Jump  input  1: jump/jr/jal redirect request.
REQ-012 JumpTarget  input  32: jump redirect address.
REQ-013 IFID_Instruction  output  32: registered fetched word.
REQ-014 IFID_PCPlus4  output  32: registered PC+4 of that word.
REQ-015 IFID_Valid  output  1: 1 = IF/ID holds a real instruction, 0 = bubble.

Function
REQ-016 Address SHALL equal the PC register combinationally; Address[1:0] SHALL always be 2'b00.
REQ-017 Redirect targets SHALL have bits [1:0] forced to 00 before use.
REQ-018 PC+4 SHALL be a 32-bit add that wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-019 Redirect priority: Jump over BranchTaken when both are asserted; the resulting address is the "redirect target".
REQ-020 FSM states: RUN, HOLD, HOLD_PEND; the reset state is RUN.
REQ-021 RUN, Stall=0, no redirect: PC <= PC+4; IF/ID <= {Instruction, PC+4, 1}.
REQ-022 RUN, Stall=0, redirect: PC <= redirect target; IF/ID <= {NOP_WORD, PC+4, 0}.
REQ-023 RUN/HOLD, Stall=1, no redirect: PC and IF/ID hold; next state HOLD.
REQ-024 Stall=1 with redirect: the target is latched into the pending register; PC holds; next state HOLD_PEND.
REQ-025 HOLD_PEND, Stall=1, new redirect: the pending target is overwritten (latest wins); otherwise it is retained.
REQ-026 HOLD, Stall=0: behave as RUN for that cycle; next state RUN.
REQ-027 HOLD_PEND, Stall=0: PC <= pending target, or the live redirect target if one is asserted that cycle; IF/ID becomes a bubble; the pending register clears; next state RUN.
REQ-028 Flush=1 SHALL load IF/ID with {NOP_WORD, current IFID_PCPlus4, 0} regardless of Stall; the PC update is still governed by REQ-021..027.
REQ-029 Fetch-to-IF/ID latency SHALL be exactly one cycle; redirect-to-new-Address latency SHALL be one edge after Stall is low.

Reset
REQ-030 On Rst=0, asynchronously: PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, pending register=0, state=RUN.
REQ-031 Reset asserted mid-stall or with a redirect pending SHALL discard all pending state.
REQ-032 The first edge after Rst deasserts SHALL fetch from RESET_PC.

Structure
REQ-033 Shared package holds the FSM state encoding (RUN=0, HOLD=1, HOLD_PEND=2), the NOP_WORD constant and the 32-bit word width.
REQ-034 One sub-module, pc_next_mux, SHALL hold the combinational next-PC select (PC+4, branch, jump, pending); the register, FSM and IF/ID logic stay in fetch_stage.

Verification
REQ-035 Reset release, no stall, memory word at index i = i*4 -> Address 0,4,8,12; IFID_Instruction 0,4,8 with Valid=1, each one cycle after its fetch.
REQ-036 BranchTaken=1, target 32'h40, at PC=8 -> next Address=32'h40; IF/ID bubble (Valid=0, NOP); next cycle IF/ID holds word 0x40.
REQ-037 Jump (target 0x80) and BranchTaken (target 0x40) in the same cycle -> Address=0x80.
REQ-038 Stall for 3 cycles with BranchTaken (target 0x20) in cycle 1 -> Address held all 3 cycles; the cycle after Stall drops Address=0x20 and IF/ID is a bubble.
REQ-039 Flush=1 with Stall=1 -> IFID_Valid=0 next cycle, PC unchanged.
REQ-040 Rst pulsed low while in HOLD_PEND -> PC=RESET_PC immediately; after release no pending redirect is taken.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: word width,
// bubble instruction word, FSM state encoding and target alignment.
package fetch_stage_pkg;

   localparam int WORD_W = 32;

   // Instruction word inserted into IF/ID when a bubble is required.
   localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HOLD      = 2'd1,
      HOLD_PEND = 2'd2
   } fetch_state_t;

   // Instruction addresses are word aligned; drop the byte offset.
   function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_pc_next_mux.sv
// Combinational next-PC select: sequential PC+4, branch, jump or a
// redirect that was parked while decode was stalling.
module pc_next_mux
   import fetch_stage_pkg::*;
(
   input  logic [WORD_W-1:0] pc,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_target,
   input  logic              jump,
   input  logic [WORD_W-1:0] jump_target,
   input  logic              use_pend,
   input  logic [WORD_W-1:0] pend_target,
   output logic [WORD_W-1:0] pc_plus4,
   output logic              redirect,
   output logic [WORD_W-1:0] redirect_target,
   output logic [WORD_W-1:0] next_pc
);

   // PC+4 wraps naturally at 2^32 because the sum is truncated to WORD_W.
   assign pc_plus4 = pc + WORD_W'(4);

   assign redirect = jump | branch_taken;

   // Jump beats branch when both are requested in the same cycle.
   assign redirect_target = jump ? align_word(jump_target) : align_word(branch_target);

   // A live redirect overrides a parked one: it is the younger request.
   assign next_pc = redirect ? redirect_target : (use_pend ? pend_target : pc_plus4);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, stall/redirect FSM and the IF/ID
// pipeline register. Instruction memory is combinational on Address.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = fetch_stage_pkg::NOP_WORD
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [WORD_W-1:0] Instruction,
   output logic [WORD_W-1:0] Address,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              BranchTaken,
   input  logic [WORD_W-1:0] BranchTarget,
   input  logic              Jump,
   input  logic [WORD_W-1:0] JumpTarget,
   output logic [WORD_W-1:0] IFID_Instruction,
   output logic [WORD_W-1:0] IFID_PCPlus4,
   output logic              IFID_Valid
);

   localparam logic [WORD_W-1:0] RESET_PC_ALIGNED = {RESET_PC[WORD_W-1:2], 2'b00};

   fetch_state_t      state_reg, state_next;
   logic [WORD_W-1:0] pc_reg, pc_next;
   logic [WORD_W-1:0] pend_reg, pend_next;
   logic [WORD_W-1:0] ifid_inst_reg, ifid_inst_next;
   logic [WORD_W-1:0] ifid_pc4_reg, ifid_pc4_next;
   logic              ifid_valid_reg, ifid_valid_next;

   logic [WORD_W-1:0] pc_plus4;
   logic              redirect;
   logic [WORD_W-1:0] redirect_target;
   logic [WORD_W-1:0] mux_pc;
   logic              in_hold_pend;

   assign in_hold_pend = (state_reg == HOLD_PEND);

   pc_next_mux u_pc_next_mux (
      .pc              (pc_reg),
      .branch_taken    (BranchTaken),
      .branch_target   (BranchTarget),
      .jump            (Jump),
      .jump_target     (JumpTarget),
      .use_pend        (in_hold_pend),
      .pend_target     (pend_reg),
      .pc_plus4        (pc_plus4),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .next_pc         (mux_pc)
   );

   // State, PC, pending redirect and IF/ID registers; reset discards everything.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_reg      <= RUN;
         pc_reg         <= RESET_PC_ALIGNED;
         pend_reg       <= '0;
         ifid_inst_reg  <= NOP_WORD;
         ifid_pc4_reg   <= '0;
         ifid_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         pend_reg       <= pend_next;
         ifid_inst_reg  <= ifid_inst_next;
         ifid_pc4_reg   <= ifid_pc4_next;
         ifid_valid_reg <= ifid_valid_next;
      end
   end

   // Next-state logic: stall parks redirects, release applies them as a bubble.
   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      pend_next       = pend_reg;
      ifid_inst_next  = ifid_inst_reg;
      ifid_pc4_next   = ifid_pc4_reg;
      ifid_valid_next = ifid_valid_reg;

      if (Stall) begin
         if (redirect) begin
            // Latest redirect wins while decode is still holding us.
            pend_next  = redirect_target;
            state_next = HOLD_PEND;
         end else if (in_hold_pend) begin
            state_next = HOLD_PEND;
         end else begin
            state_next = HOLD;
         end
      end else begin
         pc_next       = mux_pc;
         pend_next     = '0;
         state_next    = RUN;
         ifid_pc4_next = pc_plus4;
         if (redirect || in_hold_pend) begin
            // The word at the current PC is on the wrong path: squash it.
            ifid_inst_next  = NOP_WORD;
            ifid_valid_next = 1'b0;
         end else begin
            ifid_inst_next  = Instruction;
            ifid_valid_next = 1'b1;
         end
      end

      // Flush squashes IF/ID but keeps its PC+4 and never touches the PC path.
      if (Flush) begin
         ifid_inst_next  = NOP_WORD;
         ifid_pc4_next   = ifid_pc4_reg;
         ifid_valid_next = 1'b0;
      end
   end

   assign Address          = pc_reg;
   assign IFID_Instruction = ifid_inst_reg;
   assign IFID_PCPlus4     = ifid_pc4_reg;
   assign IFID_Valid       = ifid_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a vector table driven cycle by cycle
// with expected results queued on drive and compared after the edge, plus a
// hand-written reset-while-pending sequence.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic [31:0] address;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] ifid_instruction;
   logic [31:0] ifid_pcplus4;
   logic        ifid_valid;

   int tests_run    = 0;
   int tests_failed = 0;

   fetch_stage dut (
      .Clk              (clk),
      .Rst              (rst),
      .Instruction      (instruction),
      .Address          (address),
      .Stall            (stall),
      .Flush            (flush),
      .BranchTaken      (branch_taken),
      .BranchTarget     (branch_target),
      .Jump             (jump),
      .JumpTarget       (jump_target),
      .IFID_Instruction (ifid_instruction),
      .IFID_PCPlus4     (ifid_pcplus4),
      .IFID_Valid       (ifid_valid)
   );

   // Memory model: word at index i holds i*4, i.e. the word equals its address.
   assign instruction = address;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        br;
      logic [31:0] br_tgt;
      logic        jmp;
      logic [31:0] jmp_tgt;
      logic [31:0] e_addr;
      logic [31:0] e_inst;
      logic [31:0] e_pc4;
      logic        e_valid;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] addr;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
   } exp_t;

   localparam int NVEC = 22;
   vec_t vecs [NVEC];
   exp_t sb_q [$];

   function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt, input logic [31:0] ea,
                               input logic [31:0] ei, input logic [31:0] ep, input logic ev);
      vec_t v;
      v.stall = s; v.flush = f; v.br = b; v.br_tgt = bt; v.jmp = j; v.jmp_tgt = jt;
      v.e_addr = ea; v.e_inst = ei; v.e_pc4 = ep; v.e_valid = ev;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
      stall = s; flush = f; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                             input logic [31:0] ep, input logic ev);
      chk({tag, " addr"},  address, ea);
      chk({tag, " inst"},  ifid_instruction, ei);
      chk({tag, " pc4"},   ifid_pcplus4, ep);
      chk({tag, " valid"}, {31'd0, ifid_valid}, {31'd0, ev});
   endtask

   initial begin
      exp_t e;

      // stall flush br  br_tgt        jmp jmp_tgt       | addr          inst          pc4           valid
      vecs[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      32'h4,        32'h0,        32'h4,        1);
      vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      32'h8,        32'h4,        32'h8,        1);
      vecs[2]  = mk(0, 0, 1, 32'h40,       0, 32'h0,      32'h40,       32'h0,        32'hC,        0);
      vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      32'h44,       32'h40,       32'h44,       1);
      vecs[4]  = mk(0, 0, 1, 32'h40,       1, 32'h80,     32'h80,       32'h0,        32'h48,       0);
      vecs[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      32'h84,       32'h80,       32'h84,       1);
      vecs[6]  = mk(1, 0, 1, 32'h20,       0, 32'h0,      32'h84,       32'h80,       32'h84,       1);
      vecs[7]  = mk(1, 0, 0, 32'h0,        0, 32'h0,      32'h84,       32'h80,       32'h84,       1);
      vecs[8]  = mk(1, 0, 0, 32'h0,        0, 32'h0,      32'h84,       32'h80,       32'h84,       1);
      vecs[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      32'h20,       32'h0,        32'h88,       0);
      vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,      32'h24,       32'h20,       32'h24,       1);
      vecs[11] = mk(1, 0, 0, 32'h0,        0, 32'h0,      32'h24,       32'h20,       32'h24,       1);
      vecs[12] = mk(1, 1, 0, 32'h0,        0, 32'h0,      32'h24,       32'h0,        32'h24,       0);
      vecs[13] = mk(0, 0, 0, 32'h0,        0, 32'h0,      32'h28,       32'h24,       32'h28,       1);
      vecs[14] = mk(1, 0, 0, 32'h0,        1, 32'h103,    32'h28,       32'h24,       32'h28,       1);
      vecs[15] = mk(1, 0, 1, 32'h201,      0, 32'h0,      32'h28,       32'h24,       32'h28,       1);
      vecs[16] = mk(0, 0, 0, 32'h0,        1, 32'h300,    32'h300,      32'h0,        32'h2C,       0);
      vecs[17] = mk(0, 0, 0, 32'h0,        0, 32'h0,      32'h304,      32'h300,      32'h304,      1);
      vecs[18] = mk(0, 1, 0, 32'h0,        0, 32'h0,      32'h308,      32'h0,        32'h304,      0);
      vecs[19] = mk(0, 0, 1, 32'hFFFFFFFE, 0, 32'h0,      32'hFFFFFFFC, 32'h0,        32'h30C,      0);
      vecs[20] = mk(0, 0, 0, 32'h0,        0, 32'h0,      32'h0,        32'hFFFFFFFC, 32'h0,        1);
      vecs[21] = mk(0, 1, 1, 32'h10,       0, 32'h0,      32'h10,       32'h0,        32'h0,        0);

      // Reset state, held asynchronously before any clock edge.
      rst = 1'b0;
      drive(0, 0, 0, 32'h0, 0, 32'h0);
      #3;
      check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      $display("[TB] reset addr=%h ifid=%h/%h/%b", address, ifid_instruction, ifid_pcplus4, ifid_valid);
      @(posedge clk);
      #1;
      check_ifid("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0);

      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].br_tgt, vecs[i].jmp, vecs[i].jmp_tgt);
         e.idx = i; e.addr = vecs[i].e_addr; e.inst = vecs[i].e_inst;
         e.pc4 = vecs[i].e_pc4; e.valid = vecs[i].e_valid;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
         end else begin
            e = sb_q.pop_front();
            check_ifid($sformatf("vec%0d", e.idx), e.addr, e.inst, e.pc4, e.valid);
            $display("[TB] vec %0d addr=%h ifid=%h/%h/%b", e.idx, address, ifid_instruction,
                     ifid_pcplus4, ifid_valid);
         end
      end

      // Park a redirect under stall, then reset: the redirect must be forgotten.
      @(negedge clk);
      drive(1, 0, 1, 32'h40, 0, 32'h0);
      @(posedge clk);
      #1;
      chk("pend_hold addr", address, 32'h10);
      #2;
      rst = 1'b0;
      #1;
      check_ifid("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
      $display("[TB] reset in HOLD_PEND addr=%h valid=%b", address, ifid_valid);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 32'h0, 0, 32'h0);
      @(posedge clk);
      #1;
      check_ifid("post_reset", 32'h4, 32'h0, 32'h4, 1'b1);
      $display("[TB] post-reset addr=%h ifid=%h/%h/%b", address, ifid_instruction,
               ifid_pcplus4, ifid_valid);
      @(negedge clk);
      @(posedge clk);
      #1;
      check_ifid("post_reset2", 32'h8, 32'h4, 32'h8, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
